// File: rtl/seg_display_ctrl_pkg.sv
// Shared address codes, mode bits, converter states and glyph decode for the
// seven-segment display controller.
package seg_pkg;

   localparam logic [1:0] ADDR_VALUE = 2'b00;
   localparam logic [1:0] ADDR_MODE  = 2'b01;
   localparam logic [1:0] ADDR_BLANK = 2'b10;

   localparam int unsigned MODE_DEC = 0;
   localparam int unsigned MODE_LZS = 1;

   localparam logic [7:0] SEG_DASH = 8'h40;
   localparam logic [7:0] SEG_OFF  = 8'h00;

   typedef enum logic [1:0] {
      CONV_IDLE = 2'd0,
      CONV_RUN  = 2'd1,
      CONV_DONE = 2'd2
   } conv_state_e;

   // Segment order {dp,g,f,e,d,c,b,a}, active high.
   function automatic logic [7:0] hex_glyph(input logic [3:0] code);
      logic [7:0] g;
      unique case (code)
         4'h0:    g = 8'h3F;
         4'h1:    g = 8'h06;
         4'h2:    g = 8'h5B;
         4'h3:    g = 8'h4F;
         4'h4:    g = 8'h66;
         4'h5:    g = 8'h6D;
         4'h6:    g = 8'h7D;
         4'h7:    g = 8'h07;
         4'h8:    g = 8'h7F;
         4'h9:    g = 8'h6F;
         4'hA:    g = 8'h77;
         4'hB:    g = 8'h7C;
         4'hC:    g = 8'h39;
         4'hD:    g = 8'h5E;
         4'hE:    g = 8'h79;
         default: g = 8'h71;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle,
// MSB first, with a sticky overflow when the result exceeds NUM_DIGITS digits.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [DATA_W-1:0]       bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   conv_state_e       state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BCD_W-1:0]  adj;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         shreg_q <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      adj = bcd_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end

      unique case (state_q)
         CONV_IDLE: begin
         end
         CONV_RUN: begin
            // The bit leaving the top digit is what makes the result too wide.
            bcd_d   = {adj[BCD_W-2:0], shreg_q[DATA_W-1]};
            ovf_d   = ovf_q | adj[BCD_W-1];
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = CONV_DONE;
            end
         end
         CONV_DONE: begin
            state_d = CONV_IDLE;
         end
         default: begin
            state_d = CONV_IDLE;
         end
      endcase

      if (start) begin
         state_d = CONV_RUN;
         shreg_d = bin;
         bcd_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else if (abort) begin
         state_d = CONV_IDLE;
      end
   end

   assign busy = (state_q != CONV_IDLE);
   assign done = (state_q == CONV_DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped multi-digit seven-segment controller: register decode,
// display buffer (hex or converted decimal), digit rendering and scan.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned SEG_INV     = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [1:0]            wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] ena,
   output logic [7:0]            seg
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned RC_W  = $clog2(REFRESH_DIV);
   localparam int unsigned HEX_W = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;

   logic [DATA_W-1:0]           value_q, value_d;
   logic [1:0]                  mode_q, mode_d;
   logic [NUM_DIGITS-1:0]       blank_q, blank_d;
   logic [NUM_DIGITS-1:0][3:0]  disp_q, disp_d;
   logic                        ovf_q, ovf_d;
   logic [RC_W-1:0]             refresh_q, refresh_d;
   logic [IDX_W-1:0]            idx_q, idx_d;

   logic                        wr_value, wr_mode, wr_blank;
   logic                        conv_start, conv_abort, hex_load;
   logic [DATA_W-1:0]           conv_bin;
   logic                        conv_busy, conv_done, conv_ovf;
   logic [4*NUM_DIGITS-1:0]     conv_bcd;
   logic [HEX_W-1:0]            hex_src;

   logic [3:0]                  cur_code;
   logic                        nonzero_above;
   logic [7:0]                  glyph;
   logic [NUM_DIGITS-1:0]       ena_raw;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .clk   (clock),
      .rst   (reset),
      .start (conv_start),
      .abort (conv_abort),
      .bin   (conv_bin),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q   <= '0;
         mode_q    <= '0;
         blank_q   <= '0;
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         refresh_q <= '0;
         idx_q     <= '0;
      end else begin
         value_q   <= value_d;
         mode_q    <= mode_d;
         blank_q   <= blank_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
      end
   end

   always_comb begin
      value_d = value_q;
      mode_d  = mode_q;
      blank_d = blank_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;

      wr_value = wr_en && (wr_addr == ADDR_VALUE);
      wr_mode  = wr_en && (wr_addr == ADDR_MODE);
      wr_blank = wr_en && (wr_addr == ADDR_BLANK);

      if (wr_value) value_d = wr_data;
      if (wr_mode)  mode_d  = wr_data[1:0];
      if (wr_blank) blank_d = wr_data[NUM_DIGITS-1:0];

      // Conversions and hex reloads always see the contents being written now.
      conv_bin   = wr_value ? wr_data : value_q;
      conv_start = (wr_value && mode_q[MODE_DEC]) || (wr_mode && wr_data[MODE_DEC]);
      conv_abort = wr_mode && !wr_data[MODE_DEC];
      hex_load   = (wr_value && !mode_q[MODE_DEC]) || conv_abort;
      hex_src    = HEX_W'(conv_bin);

      if (hex_load) begin
         disp_d = hex_src[4*NUM_DIGITS-1:0];
         ovf_d  = 1'b0;
      end else if (conv_done) begin
         disp_d = conv_bcd;
         ovf_d  = conv_ovf;
      end
   end

   always_comb begin
      refresh_d = refresh_q + 1'b1;
      idx_d     = idx_q;
      if (refresh_q == RC_W'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      cur_code      = disp_q[idx_q];
      nonzero_above = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if ((IDX_W'(i) > idx_q) && (disp_q[i] != 4'd0)) nonzero_above = 1'b1;
      end

      if (blank_q[idx_q]) begin
         glyph = SEG_OFF;
      end else if (ovf_q && mode_q[MODE_DEC]) begin
         glyph = SEG_DASH;
      end else if (mode_q[MODE_LZS] && (cur_code == 4'd0) && !nonzero_above &&
                   (idx_q != '0)) begin
         glyph = SEG_OFF;
      end else begin
         glyph = hex_glyph(cur_code);
      end

      ena_raw        = '0;
      ena_raw[idx_q] = 1'b1;
   end

   assign busy = conv_busy;
   assign ena  = (SEG_INV != 0) ? ~ena_raw : ena_raw;
   assign seg  = (SEG_INV != 0) ? ~glyph   : glyph;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: stimulus pushes expected frames and
// busy lengths, a negedge monitor checks scan order, busy pulses and glyphs.
`timescale 1ns/1ps
module tb_seg_display_ctrl;

   localparam int unsigned ND = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned RD = 4;

   localparam logic [7:0] GLYPH [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          wr_en   = 1'b0;
   logic [1:0]    wr_addr = 2'b00;
   logic [DW-1:0] wr_data = '0;
   logic          busy;
   logic [ND-1:0] ena;
   logic [7:0]    seg;

   int checks = 0;
   int errors = 0;

   // Reference register image
   logic [31:0] m_value;
   logic [1:0]  m_mode;
   logic [7:0]  m_blank;

   logic [63:0] disp_exp_q [$];
   int          busy_exp_q [$];

   int          tb_cyc;
   int          frames_done = 0;
   int          blen = 0;
   bit          frame_active = 1'b0;
   logic [63:0] cur_frame;
   int          digits_left = 0;
   int          mon_idx;
   logic [7:0]  mon_ena;
   int          exp_len;

   seg_display_ctrl #(
      .NUM_DIGITS  (ND),
      .DATA_W      (DW),
      .REFRESH_DIV (RD),
      .SEG_INV     (0)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .ena     (ena),
      .seg     (seg)
   );

   always #5 clock = ~clock;

   always @(posedge clock or posedge reset) begin
      if (reset) tb_cyc <= 0;
      else       tb_cyc <= tb_cyc + 1;
   end

   function automatic logic [63:0] model_frame();
      logic [63:0]     f;
      logic [3:0]      d [8];
      longint unsigned v;
      int              hi;
      bit              ovf;
      v   = {32'd0, m_value};
      ovf = m_mode[0] && (v >= 64'd100000000);
      hi  = 0;
      for (int i = 0; i < 8; i++) begin
         if (m_mode[0]) begin
            d[i] = 4'(v % 10);
            v    = v / 10;
         end else begin
            d[i] = m_value[4*i +: 4];
         end
         if (d[i] != 4'd0) hi = i;
      end
      for (int i = 0; i < 8; i++) begin
         if (m_blank[i])                f[8*i +: 8] = 8'h00;
         else if (ovf)                  f[8*i +: 8] = 8'h40;
         else if (m_mode[1] && i > hi)  f[8*i +: 8] = 8'h00;
         else                           f[8*i +: 8] = GLYPH[d[i]];
      end
      return f;
   endfunction

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      if (((a == 2'b00) && m_mode[0]) || ((a == 2'b01) && d[0])) busy_exp_q.push_back(33);
      @(negedge clock);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clock);
      wr_en   = 1'b0;
      wr_addr = 2'b00;
      wr_data = '0;
      case (a)
         2'b00:   m_value = d;
         2'b01:   m_mode  = d[1:0];
         2'b10:   m_blank = d[7:0];
         default: ;
      endcase
   endtask

   task automatic settle();
      int n = 0;
      repeat (2) @(negedge clock);
      while (busy === 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL settle: busy=%b, required 0 within 200 cycles", busy);
      end
   endtask

   task automatic check_frame();
      int start = frames_done;
      int n = 0;
      disp_exp_q.push_back(model_frame());
      while (frames_done == start && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (frames_done == start) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: frame still incomplete after 100 cycles, required one");
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         blen         = 0;
         frame_active = 1'b0;
      end else begin
         mon_idx = (tb_cyc / RD) % ND;
         mon_ena = 8'(1 << mon_idx);
         checks++;
         if (ena !== mon_ena) begin
            errors++;
            $display("FAIL scan_ena: cycle %0d ena=%h, required %h", tb_cyc, ena, mon_ena);
         end

         if (busy === 1'b1) begin
            blen++;
         end else if (blen > 0) begin
            checks++;
            if (busy_exp_q.size() == 0) begin
               errors++;
               $display("FAIL busy_len: got %0d-cycle busy pulse, required none", blen);
            end else begin
               exp_len = busy_exp_q.pop_front();
               if (blen != exp_len) begin
                  errors++;
                  $display("FAIL busy_len: got %0d cycles, required %0d", blen, exp_len);
               end
            end
            blen = 0;
         end

         if (tb_cyc % RD == 0) begin
            if (!frame_active && disp_exp_q.size() > 0) begin
               cur_frame    = disp_exp_q.pop_front();
               frame_active = 1'b1;
               digits_left  = ND;
            end
            if (frame_active) begin
               checks++;
               if (seg !== cur_frame[8*mon_idx +: 8]) begin
                  errors++;
                  $display("FAIL digit_seg: digit %0d seg=%h, required %h", mon_idx, seg,
                           cur_frame[8*mon_idx +: 8]);
               end
               digits_left--;
               if (digits_left == 0) begin
                  frame_active = 1'b0;
                  frames_done++;
               end
            end
         end
      end
   end

   initial begin
      m_value = '0;
      m_mode  = '0;
      m_blank = '0;
      reset   = 1'b1;
      repeat (3) @(negedge clock);
      #1 reset = 1'b0;

      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++;
      if (ena !== 8'h01) begin errors++; $display("FAIL reset_ena: got %h, required 01", ena); end
      checks++;
      if (seg !== 8'h3F) begin errors++; $display("FAIL reset_seg: got %h, required 3f", seg); end
      check_frame();

      do_write(2'b00, 32'h1234ABCD); settle(); check_frame();
      do_write(2'b01, 32'd1);        settle(); check_frame();
      do_write(2'b00, 32'd12345678); settle(); check_frame();
      do_write(2'b01, 32'd3);        settle();
      do_write(2'b00, 32'd42);       settle(); check_frame();
      do_write(2'b01, 32'd1);        settle();
      do_write(2'b00, 32'd100000000); settle(); check_frame();

      // Restart mid-conversion: second write lands 11 cycles after the first.
      do_write(2'b00, 32'd100000000);
      repeat (9) @(negedge clock);
      do_write(2'b00, 32'd7);
      void'(busy_exp_q.pop_back());
      void'(busy_exp_q.pop_back());
      busy_exp_q.push_back(11 + 33);
      settle(); check_frame();

      do_write(2'b11, $urandom); settle(); check_frame();

      for (int t = 0; t < 25; t++) begin
         int unsigned op;
         logic [1:0]  a;
         logic [31:0] v;
         op = $urandom_range(0, 9);
         if (op < 2) begin
            a = 2'b10;
            v = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : 32'd0;
         end else if (op < 4) begin
            a = 2'b01;
            v = 32'($urandom_range(0, 3));
         end else begin
            a = 2'b00;
            case ($urandom_range(0, 2))
               0:       v = 32'($urandom_range(0, 999));
               1:       v = 32'($urandom_range(0, 99999999));
               default: v = $urandom;
            endcase
         end
         do_write(a, v);
         settle();
         check_frame();
      end

      do_write(2'b01, 32'd1);    settle();
      do_write(2'b10, 32'h0F);   settle(); check_frame();
      do_write(2'b00, 32'd55555);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b, required 0", busy); end
      busy_exp_q.delete();
      m_value = '0;
      m_mode  = '0;
      m_blank = '0;
      repeat (2) @(negedge clock);
      #1 reset = 1'b0;
      check_frame();
      repeat (40) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised, memory-mapped seven-segment display controller for the minisys CPU IO space. It generalises the fixed four-digit scan driver to NUM_DIGITS digits, adds a registered display buffer, selectable hex or decimal rendering through a sequential binary-to-BCD converter, leading-zero suppression and per-digit blanking. It sits on the MemOrIO write path and takes its write strobe from the LED/segment chip-select decode. It drives the board digit enables and segment lines.

## Interface
- NUM_DIGITS, 8, digits scanned; 1..8.
- DATA_W, 32, width of the CPU write data bus.
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; ≥2.
- SEG_INV, 0, 1 inverts `seg` and `ena` for active-low boards.
- clock  in  1  system clock, the CPU clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  one-cycle write strobe from the IO decode.
- wr_addr  in  2  register select: 00 value, 01 mode, 10 blank mask, 11 ignored.
- wr_data  in  DATA_W  write data.
- busy  out  1  decimal conversion in progress.
- ena  out  NUM_DIGITS  one-hot digit enable.
- seg  out  8  {dp,g,f,e,d,c,b,a}.

## Operation
- Registers:
  - value (DATA_W).
  - mode[1:0]: bit0 = decimal, bit1 = leading-zero suppress.
  - blank[NUM_DIGITS-1:0]: 1 = digit dark.
  - disp_buf: NUM_DIGITS 4-bit codes plus an ovf flag.
- Hex mode:
  - disp_buf digit i = value[4i+3:4i].
  - Bits above 4*NUM_DIGITS are ignored.
- Decimal mode uses a double-dabble converter:
  - One bit per cycle, MSB first.
  - For each BCD digit ≥5, add 3, then shift.
  - A 1 shifted out of the top BCD digit sets sticky ovf.
  - On completion, the BCD result and ovf are copied into disp_buf.
- Converter FSM is IDLE → CONV → DONE → IDLE:
  - IDLE → CONV when value or mode is written while mode.bit0 = 1, or when mode is written with bit0 = 1.
  - CONV → DONE after DATA_W shifts.
  - DONE → IDLE after loading disp_buf.
  - A write to value or mode during CONV restarts CONV from bit DATA_W-1 using the latest register contents. The latest write wins; no queueing.
  - Writing mode with bit0 = 0 during CONV aborts to IDLE, and disp_buf reloads as hex.
- Digit rendering, in priority order:
  1. blank[i] → all segments off.
  2. ovf (decimal only) → dash, segment g only.
  3. Leading-zero suppress → a zero digit above the highest non-zero digit is off. Digit 0 always shows.
  4. Otherwise → hex glyph 0–F.
  - dp is always off.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances, wrapping NUM_DIGITS-1 → 0.
  - `ena` = one-hot(index).
  - `seg` = glyph of disp_buf[index], applied in the same cycle as `ena`.

## Timing
- Reset state:
  - value = 0, mode = 0, blank = 0, disp_buf = 0, ovf = 0, FSM in IDLE.
  - refresh_cnt = 0, index = 0, busy = 0.
  - ena = digit 0 selected; seg = glyph '0' (0x3F before SEG_INV).
- Write latency: registers update on the clock edge where wr_en = 1.
- Hex mode: disp_buf updates on that same edge, so the new glyph is visible at the next scan of that digit.
- Decimal mode:
  - busy rises the cycle after the write.
  - busy stays high for DATA_W+1 cycles (DATA_W shifts plus DONE).
  - disp_buf updates on the DONE edge; busy falls the next cycle.
- Blank-mask writes take effect on the next edge, without conversion.
- Digit dwell is exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS×REFRESH_DIV cycles.
- Writes never disturb refresh_cnt or index.
- Reset mid-conversion: busy drops immediately (asynchronously) and disp_buf clears.
- wr_addr = 11: no state change.

## Structure
- Package seg_pkg holds:
  - Address codes: ADDR_VALUE, ADDR_MODE, ADDR_BLANK.
  - Mode bit indices.
  - SEG_DASH = 8'h40.
  - The hex-to-segment glyph function.
- Sub-module bin2bcd_seq holds the double-dabble FSM:
  - Parameters DATA_W, NUM_DIGITS.
  - Ports start, bin, busy, done, bcd, ovf.
- The top handles register decode, disp_buf and the scan counter.

## Test plan
- Reset then idle, with NUM_DIGITS=8 and REFRESH_DIV=4:
  - ena cycles 0x01,0x02,…,0x80,0x01, each held 4 cycles.
  - Every seg = 0x3F.
- Hex mode, write value=0x1234ABCD:
  - Digit 0 shows 0x5E ('d'); digit 7 shows 0x06 ('1').
  - busy stays 0.
- Decimal mode, write 12345678:
  - busy high for 33 cycles.
  - Digit 0 shows '8'; digit 7 shows '1'.
- Decimal with leading-zero suppress, write 42:
  - Digits 2–7 off; digit 1 = '4'; digit 0 = '2'.
- Decimal, write 100000000 (exceeds 8 digits):
  - All digits show 0x40.
  - A second write of 7 mid-conversion restarts conversion: only digit 0 = '7', no dashes.
- Blank mask 0x0F, then assert reset mid-conversion:
  - Low four digits dark.
  - After reset: busy = 0, mask cleared, all digits '0'.
